// File: rtl/noc_buffer_out.sv
// Tile-to-NoC egress buffer. AXI-Stream words from the tile are stored in
// a circular memory and a packet is only released to the NoC once its
// TLAST word is stored. If a packet fills the whole buffer without a TLAST,
// the buffer falls back to cut-through so it can never deadlock.
//
// Handshakes on both streams: a word moves on a posedge where TVALID and
// TREADY are both high. Once stream_out_TVALID is raised, TDATA/TKEEP/TLAST
// stay stable until the NoC accepts the word.
module noc_buffer_out #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              clk_rst_low,
  input  logic              stream_in_TVALID,
  input  logic [31:0]       stream_in_TDATA,
  input  logic [3:0]        stream_in_TKEEP,
  input  logic              stream_in_TLAST,
  output logic              stream_in_TREADY,
  output logic              stream_out_TVALID,
  output logic [31:0]       stream_out_TDATA,
  output logic [3:0]        stream_out_TKEEP,
  output logic              stream_out_TLAST,
  input  logic              stream_out_TREADY,
  output logic [ADDR_W:0]   word_count,
  output logic [ADDR_W:0]   pkt_count,
  output logic              oversize_pkt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, SEND, STALL} state_t;

  state_t          state;
  logic [36:0]     mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [36:0]     rd_word;
  logic [36:0]     out_reg;
  logic            full;
  logic            wr_en;
  logic            rd_en;
  logic            rd_last;
  logic            out_hs;
  logic            ct_set;
  logic            cut_through;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign word_count       = wr_ptr - rd_ptr;
  assign full             = (word_count == FULL_CNT);
  // A slot freed by a read this cycle only becomes writable next cycle.
  assign stream_in_TREADY = clk_rst_low & ~full;
  assign wr_en            = stream_in_TVALID & stream_in_TREADY;

  assign rd_word = mem[rd_ptr[ADDR_W-1:0]];
  assign rd_last = rd_word[36];

  assign stream_out_TVALID = (state == SEND);
  assign {stream_out_TLAST, stream_out_TKEEP, stream_out_TDATA} = out_reg;
  assign out_hs = stream_out_TVALID & stream_out_TREADY;

  // Buffer full with no complete packet inside: only cut-through can drain it.
  assign ct_set       = full & (pkt_count == '0);
  assign oversize_pkt = clk_rst_low & ct_set & ~cut_through;

  // Decide when to pop the next word from memory into the output register.
  always_comb begin
    rd_en = 1'b0;
    case (state)
      IDLE:    rd_en = ((pkt_count != '0) | cut_through) & (word_count != '0);
      SEND:    rd_en = out_hs & ~stream_out_TLAST & (word_count != '0);
      STALL:   rd_en = (word_count != '0);
      default: rd_en = 1'b0;
    endcase
  end

  // Word storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= {stream_in_TLAST, stream_in_TKEEP, stream_in_TDATA};
  end

  // Pointers, packet bookkeeping, cut-through flag and the output FSM.
  always_ff @(posedge clk) begin
    if (!clk_rst_low) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pkt_count   <= '0;
      cut_through <= 1'b0;
      out_reg     <= '0;
      state       <= IDLE;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ONE;
      if (rd_en) begin
        rd_ptr  <= rd_ptr + ONE;
        out_reg <= rd_word;
      end

      case ({wr_en & stream_in_TLAST, rd_en & rd_last})
        2'b10:   pkt_count <= pkt_count + ONE;
        2'b01:   pkt_count <= pkt_count - ONE;
        default: ;
      endcase

      // A new oversize packet wins over the end of the previous one.
      if (ct_set)                        cut_through <= 1'b1;
      else if (out_hs & stream_out_TLAST) cut_through <= 1'b0;

      case (state)
        IDLE: begin
          if (rd_en) state <= SEND;
        end
        SEND: begin
          if (out_hs) begin
            if (stream_out_TLAST) state <= IDLE;
            else if (rd_en)       state <= SEND;
            else                  state <= STALL;
          end
        end
        STALL: begin
          if (rd_en) state <= SEND;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_buffer_out.sv
// Bench for noc_buffer_out with an 8-word buffer. The reference is a queue
// of every word the tile handed over and the NoC has not yet taken; stored
// word/packet counts, release rules and ordering are all derived from it.
module tb_noc_buffer_out;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          clk_rst_low;
  logic          in_valid, in_last, in_ready;
  logic [31:0]   in_data;
  logic [3:0]    in_keep;
  logic          out_valid, out_last, out_ready;
  logic [31:0]   out_data;
  logic [3:0]    out_keep;
  logic [AW:0]   word_count, pkt_count;
  logic          oversize;

  noc_buffer_out #(.ADDR_W(AW)) dut (
    .clk               (clk),
    .clk_rst_low       (clk_rst_low),
    .stream_in_TVALID  (in_valid),
    .stream_in_TDATA   (in_data),
    .stream_in_TKEEP   (in_keep),
    .stream_in_TLAST   (in_last),
    .stream_in_TREADY  (in_ready),
    .stream_out_TVALID (out_valid),
    .stream_out_TDATA  (out_data),
    .stream_out_TKEEP  (out_keep),
    .stream_out_TLAST  (out_last),
    .stream_out_TREADY (out_ready),
    .word_count        (word_count),
    .pkt_count         (pkt_count),
    .oversize_pkt      (oversize)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard and reference state
  logic [36:0] exp_q[$];
  int          n_checks, n_errors;
  bit          m_ct;
  bit          prev_hold, prev_last_hs;
  logic [36:0] prev_word;
  int          ovs_seen, pkt_words, last_pkt_len;
  bit          stall_seen;
  int          rdy_mode;
  bit          tog;
  logic        acc_m;

  typedef struct {
    logic        v;
    logic [36:0] w;
    logic        ev;
    logic [36:0] ew;
  } vec_t;
  vec_t tv[10];

  function automatic logic [36:0] mk(input logic [31:0] d, input logic [3:0] k, input logic l);
    return {l, k, d};
  endfunction

  function automatic int q_lasts();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i][36]) n++;
    return n;
  endfunction

  function automatic logic next_ready();
    case (rdy_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2: begin
        tog = ~tog;
        return tog;
      end
      default: return ($urandom_range(0, 1) == 1);
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, update the reference on handshakes, check after the edge.
  task automatic step(input logic rst_n, input logic v, input logic [36:0] w,
                      input logic r, output logic acc);
    logic        wr, rd, set_c;
    logic [36:0] ow, e;
    int          mem_w, mem_p;
    clk_rst_low = rst_n;
    in_valid    = v;
    {in_last, in_keep, in_data} = w;
    out_ready   = r;
    #1;
    ow    = {out_last, out_keep, out_data};
    wr    = rst_n & v & in_ready;
    rd    = rst_n & out_valid & r;
    acc   = wr;
    mem_w = exp_q.size() - int'(out_valid);
    mem_p = q_lasts() - int'(out_valid & out_last);
    set_c = rst_n && (mem_w == DEPTH) && (mem_p == 0);
    chk("oversize_pkt", 64'(oversize), 64'(set_c && !m_ct));
    if (!rst_n) chk("in_ready_rst", 64'(in_ready), 64'(0));
    if (oversize) ovs_seen++;
    if (m_ct && !out_valid && pkt_words > 0) stall_seen = 1'b1;
    if (rd) begin
      if (exp_q.size() == 0) begin
        chk("out_unexpected", 64'(ow), 64'(0) - 64'(1));
      end else begin
        e = exp_q.pop_front();
        chk("out_word", 64'(ow), 64'(e));
      end
      pkt_words++;
      if (out_last) begin
        last_pkt_len = pkt_words;
        pkt_words    = 0;
      end
    end
    if (wr) exp_q.push_back(w);
    if (set_c)                m_ct = 1'b1;
    else if (rd && out_last)  m_ct = 1'b0;
    prev_hold    = rst_n & out_valid & ~r;
    prev_word    = ow;
    prev_last_hs = rd & out_last;
    @(posedge clk);
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      m_ct         = 1'b0;
      pkt_words    = 0;
      prev_hold    = 1'b0;
      prev_last_hs = 1'b0;
    end
    ow = {out_last, out_keep, out_data};
    if (prev_hold) begin
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_word", 64'(ow), 64'(prev_word));
    end
    if (prev_last_hs) chk("bubble", 64'(out_valid), 64'(0));
    chk("held_words", 64'(word_count) + 64'(out_valid), 64'(exp_q.size()));
    chk("held_pkts", 64'(pkt_count) + 64'(out_valid & out_last), 64'(q_lasts()));
    chk("in_ready", 64'(in_ready), 64'(clk_rst_low && (int'(word_count) != DEPTH)));
    if (out_valid && !m_ct) chk("early_release", 64'(q_lasts() != 0), 64'(1));
  endtask

  task automatic send_word(input logic [36:0] w);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) step(1'b1, 1'b1, w, next_ready(), acc);
    chk("send_accepted", 64'(acc), 64'(1));
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, next_ready(), acc);
  endtask

  task automatic drain(input int budget);
    logic acc;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step(1'b1, 1'b0, '0, next_ready(), acc);
    chk("drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    logic [36:0] pend[$];
    logic [36:0] w10;
    int          gaps, len;
    bit          started;
    n_checks = 0; n_errors = 0; m_ct = 0; prev_hold = 0; prev_last_hs = 0;
    ovs_seen = 0; pkt_words = 0; last_pkt_len = 0; stall_seen = 0;
    rdy_mode = 1; tog = 0; prev_word = '0;
    clk_rst_low = 1'b0; in_valid = 0; in_data = '0; in_keep = '0; in_last = 0; out_ready = 0;
    @(negedge clk);

    // Reset state
    step(1'b0, 1'b0, '0, 1'b0, acc_m);
    step(1'b0, 1'b0, '0, 1'b0, acc_m);
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_out_word", 64'({out_last, out_keep, out_data}), 64'(0));
    chk("rst_word_count", 64'(word_count), 64'(0));
    chk("rst_pkt_count", 64'(pkt_count), 64'(0));
    chk("rst_oversize", 64'(oversize), 64'(0));

    // 1: four-word packet, output valid two cycles after its TLAST, contiguous
    tv[0] = '{1'b1, mk(32'hA0A0_0000, 4'hF, 1'b0), 1'b0, '0};
    tv[1] = '{1'b1, mk(32'hA0A0_0001, 4'hF, 1'b0), 1'b0, '0};
    tv[2] = '{1'b1, mk(32'hA0A0_0002, 4'hF, 1'b0), 1'b0, '0};
    tv[3] = '{1'b1, mk(32'hA0A0_0003, 4'h3, 1'b1), 1'b0, '0};
    tv[4] = '{1'b0, '0, 1'b1, mk(32'hA0A0_0000, 4'hF, 1'b0)};
    tv[5] = '{1'b0, '0, 1'b1, mk(32'hA0A0_0001, 4'hF, 1'b0)};
    tv[6] = '{1'b0, '0, 1'b1, mk(32'hA0A0_0002, 4'hF, 1'b0)};
    tv[7] = '{1'b0, '0, 1'b1, mk(32'hA0A0_0003, 4'h3, 1'b1)};
    tv[8] = '{1'b0, '0, 1'b0, '0};
    tv[9] = '{1'b0, '0, 1'b0, '0};
    for (int i = 0; i < 10; i++) begin
      step(1'b1, tv[i].v, tv[i].w, 1'b1, acc_m);
      chk($sformatf("t1_valid_%0d", i), 64'(out_valid), 64'(tv[i].ev));
      if (tv[i].ev) chk($sformatf("t1_word_%0d", i), 64'({out_last, out_keep, out_data}), 64'(tv[i].ew));
    end

    // 2: same packet shape with NoC ready toggling
    rdy_mode = 2;
    for (int i = 0; i < 4; i++) send_word(mk(32'hB000_0000 + 32'(i), 4'hF, i == 3));
    drain(60);
    chk("t2_len", 64'(last_pkt_len), 64'(4));

    // 3: packets of 1, 2 and 5 words, one idle cycle at each boundary
    rdy_mode = 0;
    send_word(mk(32'hC100_0000, 4'h1, 1'b1));
    for (int i = 0; i < 2; i++) send_word(mk(32'hC200_0000 + 32'(i), 4'h3, i == 1));
    for (int i = 0; i < 5; i++) send_word(mk(32'hC500_0000 + 32'(i), 4'h7, i == 4));
    rdy_mode = 1; started = 0; gaps = 0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      if (out_valid) started = 1;
      else if (started) gaps++;
      step(1'b1, 1'b0, '0, 1'b1, acc_m);
    end
    chk("t3_drained", 64'(exp_q.size()), 64'(0));
    chk("t3_gaps", 64'(gaps), 64'(2));

    // 4: single-word packets with NoC stalled until the buffer is full
    rdy_mode = 0;
    for (int i = 0; i < 9; i++) send_word(mk(32'hD000_0000 + 32'(i), 4'hF, 1'b1));
    chk("t4_in_ready", 64'(in_ready), 64'(0));
    chk("t4_pkt_count", 64'(pkt_count), 64'(8));
    chk("t4_word_count", 64'(word_count), 64'(8));
    chk("t4_out_valid", 64'(out_valid), 64'(1));
    w10 = mk(32'hD000_0009, 4'hF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, w10, 1'b0, acc_m);
      chk("t4_blocked", 64'(acc_m), 64'(0));
    end
    rdy_mode = 1;
    send_word(w10);
    drain(60);
    chk("t4_len", 64'(last_pkt_len), 64'(1));

    // 5: 12-word packet overflows the buffer and goes out cut-through
    ovs_seen = 0; stall_seen = 0; rdy_mode = 1;
    for (int i = 0; i < 9; i++) send_word(mk(32'hE000_0000 + 32'(i), 4'hF, 1'b0));
    idle(12);
    for (int i = 9; i < 12; i++) begin
      send_word(mk(32'hE000_0000 + 32'(i), 4'hF, i == 11));
      idle(3);
    end
    drain(60);
    chk("t5_oversize_pulses", 64'(ovs_seen), 64'(1));
    chk("t5_stall_seen", 64'(stall_seen), 64'(1));
    chk("t5_len", 64'(last_pkt_len), 64'(12));

    // 6: reset while word 3 of a 6-word packet is on the output
    rdy_mode = 0;
    for (int i = 0; i < 6; i++) send_word(mk(32'hF000_0000 + 32'(i), 4'hF, i == 5));
    for (int i = 0; i < 20 && !(pkt_words == 2 && out_valid); i++) step(1'b1, 1'b0, '0, 1'b1, acc_m);
    chk("t6_word3", 64'({out_valid, out_data}), {31'd0, 1'b1, 32'hF000_0002});
    step(1'b0, 1'b0, '0, 1'b1, acc_m);
    chk("t6_valid", 64'(out_valid), 64'(0));
    chk("t6_word_count", 64'(word_count), 64'(0));
    chk("t6_pkt_count", 64'(pkt_count), 64'(0));
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, '0, 1'b1, acc_m);
      chk("t6_no_residue", 64'(out_valid), 64'(0));
    end

    // Random packets (including oversize ones) with random valid/ready
    rdy_mode = 3;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++)
        pend.push_back(mk($urandom, 4'($urandom_range(0, 15)), i == len - 1));
    end
    for (int i = 0; i < 6000 && pend.size() != 0; i++) begin
      if (pend.size() != 0 && $urandom_range(0, 3) != 0) begin
        step(1'b1, 1'b1, pend[0], next_ready(), acc_m);
        if (acc_m) void'(pend.pop_front());
      end else begin
        step(1'b1, 1'b0, '0, next_ready(), acc_m);
      end
    end
    chk("rand_all_sent", 64'(pend.size()), 64'(0));
    drain(400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
